// File: rtl/vx_wb_commit_arb_if.sv
// Bundle between the execute units and the writeback commit arbiter.
// Carries the per-unit result beats, their grants, the writeback bus and the perf counters.
interface vx_wb_commit_arb_if #(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_THREADS   = 4,
    parameter int XLEN          = 32,
    parameter int NW_BITS       = 2,
    parameter int NR_BITS       = 6,
    parameter int PERF_CTR_BITS = 44
);
    logic [NUM_INPUTS-1:0]                  in_valid;
    logic [NUM_INPUTS-1:0]                  in_ready;
    logic [NUM_INPUTS*NW_BITS-1:0]          in_wid;
    logic [NUM_INPUTS*NUM_THREADS-1:0]      in_tmask;
    logic [NUM_INPUTS*NR_BITS-1:0]          in_rd;
    logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] in_data;
    logic [NUM_INPUTS-1:0]                  in_eop;

    logic                                   wb_valid;
    logic [NW_BITS-1:0]                     wb_wid;
    logic [NUM_THREADS-1:0]                 wb_tmask;
    logic [NR_BITS-1:0]                     wb_rd;
    logic [NUM_THREADS*XLEN-1:0]            wb_data;
    logic                                   wb_eop;

    logic [PERF_CTR_BITS-1:0]               perf_commits;
    logic [PERF_CTR_BITS-1:0]               perf_stalls;

    modport master (
        output in_valid, in_wid, in_tmask, in_rd, in_data, in_eop,
        input  in_ready,
        input  wb_valid, wb_wid, wb_tmask, wb_rd, wb_data, wb_eop,
        input  perf_commits, perf_stalls
    );

    modport slave (
        input  in_valid, in_wid, in_tmask, in_rd, in_data, in_eop,
        output in_ready,
        output wb_valid, wb_wid, wb_tmask, wb_rd, wb_data, wb_eop,
        output perf_commits, perf_stalls
    );
endinterface

// File: rtl/vx_wb_commit_arb.sv
// Round-robin writeback commit arbiter: one execute-unit beat per cycle onto the register-file
// writeback bus, locked to one unit for multi-beat results, with commit/stall counters.
module vx_wb_commit_arb #(
    parameter int NUM_INPUTS    = 4,
    parameter int NUM_THREADS   = 4,
    parameter int XLEN          = 32,
    parameter int NW_BITS       = 2,
    parameter int NR_BITS       = 6,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic             clk,
    input  logic             reset,
    vx_wb_commit_arb_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_INPUTS);
    localparam int DW    = NUM_THREADS * XLEN;

    logic [IDX_W-1:0]         rr_ptr_r;
    logic [IDX_W-1:0]         lock_idx_r;
    logic                     lock_r;

    logic                     wb_valid_r;
    logic [NW_BITS-1:0]       wb_wid_r;
    logic [NUM_THREADS-1:0]   wb_tmask_r;
    logic [NR_BITS-1:0]       wb_rd_r;
    logic [DW-1:0]            wb_data_r;
    logic                     wb_eop_r;
    logic [PERF_CTR_BITS-1:0] perf_commits_r;
    logic [PERF_CTR_BITS-1:0] perf_stalls_r;

    logic [NUM_INPUTS-1:0]    grant_s;
    logic [IDX_W-1:0]         grant_idx_s;
    logic                     grant_any_s;
    logic [IDX_W-1:0]         next_ptr_s;
    logic                     stall_s;

    // Grant selection: the lock owner only while locked, otherwise first valid from rr_ptr.
    always_comb begin : p_arb
        int idx_v;
        idx_v       = 0;
        grant_s     = '0;
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        if (lock_r) begin
            grant_idx_s = lock_idx_r;
            grant_any_s = bus.in_valid[lock_idx_r];
        end else begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                idx_v = int'(rr_ptr_r) + k;
                idx_v = (idx_v >= NUM_INPUTS) ? (idx_v - NUM_INPUTS) : idx_v;
                if (!grant_any_s && bus.in_valid[IDX_W'(idx_v)]) begin
                    grant_any_s = 1'b1;
                    grant_idx_s = IDX_W'(idx_v);
                end else begin
                    grant_any_s = grant_any_s;
                end
            end
        end
        grant_s[grant_idx_s] = grant_any_s;
    end

    // Pointer successor of the granted unit and the stall condition for the perf counter.
    always_comb begin
        next_ptr_s = (int'(grant_idx_s) == NUM_INPUTS - 1) ? IDX_W'(0) : (grant_idx_s + IDX_W'(1));
        stall_s    = |(bus.in_valid & ~grant_s);
    end

    // Arbitration state, writeback register stage and performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r       <= '0;
            lock_r         <= 1'b0;
            lock_idx_r     <= '0;
            wb_valid_r     <= 1'b0;
            wb_wid_r       <= '0;
            wb_tmask_r     <= '0;
            wb_rd_r        <= '0;
            wb_data_r      <= '0;
            wb_eop_r       <= 1'b0;
            perf_commits_r <= '0;
            perf_stalls_r  <= '0;
        end else begin
            wb_valid_r <= grant_any_s;
            if (grant_any_s) begin
                wb_wid_r   <= bus.in_wid[grant_idx_s*NW_BITS +: NW_BITS];
                wb_tmask_r <= bus.in_tmask[grant_idx_s*NUM_THREADS +: NUM_THREADS];
                wb_rd_r    <= bus.in_rd[grant_idx_s*NR_BITS +: NR_BITS];
                wb_data_r  <= bus.in_data[grant_idx_s*DW +: DW];
                wb_eop_r   <= bus.in_eop[grant_idx_s];
                if (bus.in_eop[grant_idx_s]) begin
                    lock_r         <= 1'b0;
                    rr_ptr_r       <= next_ptr_s;
                    perf_commits_r <= perf_commits_r + PERF_CTR_BITS'(1);
                end else begin
                    // Mid-instruction beat: pin the unit so its remaining beats stay contiguous.
                    lock_r     <= 1'b1;
                    lock_idx_r <= grant_idx_s;
                end
            end else begin
                wb_eop_r <= wb_eop_r;
            end
            if (stall_s) begin
                perf_stalls_r <= perf_stalls_r + PERF_CTR_BITS'(1);
            end else begin
                perf_stalls_r <= perf_stalls_r;
            end
        end
    end

    assign bus.in_ready     = grant_s;
    assign bus.wb_valid     = wb_valid_r;
    assign bus.wb_wid       = wb_wid_r;
    assign bus.wb_tmask     = wb_tmask_r;
    assign bus.wb_rd        = wb_rd_r;
    assign bus.wb_data      = wb_data_r;
    assign bus.wb_eop       = wb_eop_r;
    assign bus.perf_commits = perf_commits_r;
    assign bus.perf_stalls  = perf_stalls_r;
endmodule
